// File: rtl/pll_lock_monitor.sv
// PLL lock and frequency monitor.
// Holds the core reset until the audio PLL reports lock and its output frequency has been in
// range for GOOD_WINDOWS consecutive measurement windows. After release it reports lock loss
// and frequency faults until they are cleared.
module pll_lock_monitor #(
    parameter int unsigned GATE_CYCLES  = 1000,
    parameter int unsigned EXPECT_COUNT = 226,
    parameter int unsigned TOLERANCE    = 4,
    parameter int unsigned GOOD_WINDOWS = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             mon_clk,
    input  logic             fault_clr,
    output logic             sys_rst,
    output logic             clk_ok,
    output logic             fault,
    output logic [1:0]       fault_cause,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid
);

    localparam int unsigned GateW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int unsigned GoodW = (GOOD_WINDOWS > 1) ? $clog2(GOOD_WINDOWS + 1) : 1;
    localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    // Lower bound clamps at zero so a tolerance wider than the target cannot underflow.
    localparam longint unsigned RangeLo =
        (EXPECT_COUNT > TOLERANCE) ? longint'(EXPECT_COUNT - TOLERANCE) : 64'd0;
    localparam longint unsigned RangeHi = longint'(EXPECT_COUNT) + longint'(TOLERANCE);

    typedef enum logic [1:0] {
        StWaitLock,
        StMeasure,
        StRun,
        StFault
    } state_e;

    // Synchroniser and edge-detect flops.
    logic lock_meta_q;
    logic lock_sync_q;
    logic mon_meta_q;
    logic mon_sync_q;
    logic mon_prev_q;

    // Measurement window state.
    logic [GateW-1:0] gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] meas_count_q, meas_count_d;
    logic             meas_valid_q, meas_valid_d;

    // Supervisor state.
    state_e           state_q, state_d;
    logic [GoodW-1:0] good_cnt_q, good_cnt_d;
    logic [1:0]       fault_cause_q, fault_cause_d;

    // Combinational helpers.
    logic             win_end;
    logic             mon_rise;
    logic [CNT_W-1:0] win_count;
    logic             in_range;
    logic             lock_lost;
    logic             freq_bad;
    logic             restart;
    logic [GoodW-1:0] good_inc;

    // Bring pll_locked and mon_clk into the clk domain; mon_clk gets a third flop for edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
            mon_meta_q  <= 1'b0;
            mon_sync_q  <= 1'b0;
            mon_prev_q  <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked;
            lock_sync_q <= lock_meta_q;
            mon_meta_q  <= mon_clk;
            mon_sync_q  <= mon_meta_q;
            mon_prev_q  <= mon_sync_q;
        end
    end

    // Window decode: terminal cycle, rising edge, saturating count for this window, range test.
    always_comb begin
        win_end   = (gate_cnt_q == GateLast);
        mon_rise  = mon_sync_q & ~mon_prev_q;
        win_count = edge_cnt_q;
        // An edge on the terminal cycle still belongs to the closing window.
        if (mon_rise && (edge_cnt_q != CntMax)) begin
            win_count = edge_cnt_q + 1'b1;
        end
        in_range  = (64'(win_count) >= RangeLo) && (64'(win_count) <= RangeHi);
        lock_lost = ~lock_sync_q;
        freq_bad  = win_end & ~in_range;
    end

    // Window counters: gate wraps every GATE_CYCLES, result latched on the terminal cycle.
    always_comb begin
        gate_cnt_d   = win_end ? '0 : gate_cnt_q + 1'b1;
        edge_cnt_d   = win_end ? '0 : win_count;
        meas_count_d = win_end ? win_count : meas_count_q;
        meas_valid_d = win_end;
        // Lock acquisition starts a fresh window so the first qualified window is a full one.
        if (restart) begin
            gate_cnt_d = '0;
            edge_cnt_d = '0;
        end
    end

    // Window registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            meas_count_q <= '0;
            meas_valid_q <= 1'b0;
        end else begin
            gate_cnt_q   <= gate_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            meas_count_q <= meas_count_d;
            meas_valid_q <= meas_valid_d;
        end
    end

    // Supervisor next-state: lock wait, qualification, run and latched fault.
    always_comb begin
        state_d       = state_q;
        good_cnt_d    = good_cnt_q;
        fault_cause_d = fault_cause_q;
        restart       = 1'b0;
        good_inc      = good_cnt_q + 1'b1;
        unique case (state_q)
            StWaitLock: begin
                if (lock_sync_q) begin
                    state_d    = StMeasure;
                    good_cnt_d = '0;
                    restart    = 1'b1;
                end
            end
            StMeasure: begin
                // Losing lock while still qualifying is not a fault, just start over.
                if (lock_lost) begin
                    state_d    = StWaitLock;
                    good_cnt_d = '0;
                end else if (win_end) begin
                    if (in_range) begin
                        good_cnt_d = good_inc;
                        if (32'(good_inc) >= GOOD_WINDOWS) begin
                            state_d = StRun;
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end
            end
            StRun: begin
                if (lock_lost || freq_bad) begin
                    state_d       = StFault;
                    fault_cause_d = {freq_bad, lock_lost};
                end
            end
            StFault: begin
                if (fault_clr) begin
                    state_d       = StWaitLock;
                    fault_cause_d = 2'b00;
                end
            end
            default: begin
                state_d       = StWaitLock;
                good_cnt_d    = '0;
                fault_cause_d = 2'b00;
            end
        endcase
    end

    // Supervisor registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StWaitLock;
            good_cnt_q    <= '0;
            fault_cause_q <= 2'b00;
        end else begin
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            fault_cause_q <= fault_cause_d;
        end
    end

    // Outputs decode straight from registers so they are glitch-free into the reset tree.
    assign sys_rst     = (state_q != StRun);
    assign clk_ok      = (state_q == StRun);
    assign fault       = (state_q == StFault);
    assign fault_cause = fault_cause_q;
    assign meas_count  = meas_count_q;
    assign meas_valid  = meas_valid_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Self-checking bench for pll_lock_monitor.
module tb_pll_lock_monitor;

    localparam int ClkHalf     = 10000;  // 50 MHz system clock
    localparam int MonHalf     = 44286;  // ~11.29 MHz free-running PLL output
    localparam int ExpectCount = 226;
    localparam int Tol         = 4;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        pll_locked = 1'b0;
    logic        fault_clr  = 1'b0;
    logic        mon_async  = 1'b0;
    logic        mon_pat    = 1'b0;
    logic        use_async  = 1'b1;
    logic        mon_clk;
    logic        sys_rst;
    logic        clk_ok;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [15:0] meas_count;
    logic        meas_valid;

    int checks  = 0;
    int errors  = 0;
    int pat_n   = ExpectCount;
    int pat_idx = 0;

    assign mon_clk = use_async ? mon_async : mon_pat;

    pll_lock_monitor #(
        .GATE_CYCLES (1000),
        .EXPECT_COUNT(226),
        .TOLERANCE   (4),
        .GOOD_WINDOWS(3),
        .CNT_W       (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .mon_clk    (mon_clk),
        .fault_clr  (fault_clr),
        .sys_rst    (sys_rst),
        .clk_ok     (clk_ok),
        .fault      (fault),
        .fault_cause(fault_cause),
        .meas_count (meas_count),
        .meas_valid (meas_valid)
    );

    initial forever #ClkHalf clk = ~clk;

    // Odd phase offset keeps asynchronous mon_clk transitions off clk edges.
    initial begin
        #1;
        forever begin
            mon_async = ~mon_async;
            #MonHalf;
        end
    end

    // Pattern with exactly n single-cycle pulses per 1000 cycles: any window sees exactly n edges.
    function automatic logic pat_high(input int idx, input int n);
        if (n <= 0) return 1'b0;
        return ((idx + 1) * n / 1000) > (idx * n / 1000);
    endfunction

    function automatic logic in_window(input int c);
        return (c >= ExpectCount - Tol) && (c <= ExpectCount + Tol);
    endfunction

    initial forever begin
        @(negedge clk);
        pat_idx = (pat_idx == 999) ? 0 : pat_idx + 1;
        mon_pat = pat_high(pat_idx, pat_n);
    end

    // Returns number of negedges until meas_valid is seen, -1 on timeout.
    task automatic wait_valid(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (meas_valid) begin
                n = i;
                return;
            end
        end
    endtask

    // Raise lock well away from any free-running window end.
    task automatic lock_after_valid();
        int n;
        wait_valid(1100, n);
        repeat ($urandom_range(5, 40)) @(negedge clk);
        pll_locked = 1'b1;
    endtask

    task automatic unlock_and_clear();
        @(negedge clk);
        pll_locked = 1'b0;
        repeat (5) @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk);
        checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL reset_sys_rst: got %b want 1", sys_rst); end
        checks++; if (clk_ok !== 1'b0) begin errors++; $display("FAIL reset_clk_ok: got %b want 0", clk_ok); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
        checks++; if (fault_cause !== 2'b00) begin errors++; $display("FAIL reset_cause: got %b want 00", fault_cause); end
        checks++; if (meas_count !== 16'd0) begin errors++; $display("FAIL reset_meas: got %0d want 0", meas_count); end
        checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", meas_valid); end
        rst = 1'b0;
    endtask

    task automatic test_lock_release();
        int n;
        lock_after_valid();
        for (int k = 1; k <= 3; k++) begin
            wait_valid(1100, n);
            checks++; if (n != ((k == 1) ? 1003 : 1000)) begin errors++; $display("FAIL lock_win%0d_latency: got %0d want %0d", k, n, (k == 1) ? 1003 : 1000); end
            checks++; if (meas_count < 225 || meas_count > 226) begin errors++; $display("FAIL lock_win%0d_count: got %0d want 225..226", k, meas_count); end
            checks++; if (clk_ok !== (k == 3)) begin errors++; $display("FAIL lock_win%0d_clk_ok: got %b want %b", k, clk_ok, k == 3); end
        end
        checks++; if (sys_rst !== 1'b0) begin errors++; $display("FAIL lock_sys_rst: got %b want 0", sys_rst); end
    endtask

    task automatic test_lock_loss();
        int n;
        int cyc;
        @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        @(negedge clk);
        checks++; if (clk_ok !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL clr_in_run: clk_ok=%b fault=%b want 1/0", clk_ok, fault); end
        wait_valid(1100, n);
        pll_locked = 1'b0;
        cyc = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (sys_rst) begin
                cyc = i;
                break;
            end
        end
        checks++; if (cyc < 1 || cyc > 3) begin errors++; $display("FAIL loss_latency: got %0d edges want 1..3", cyc); end
        @(negedge clk);
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL loss_fault: got %b want 1", fault); end
        checks++; if (fault_cause !== 2'b01) begin errors++; $display("FAIL loss_cause: got %b want 01", fault_cause); end
        checks++; if (clk_ok !== 1'b0) begin errors++; $display("FAIL loss_clk_ok: got %b want 0", clk_ok); end
        wait_valid(1100, n);
        checks++; if (fault !== 1'b1 || fault_cause !== 2'b01) begin errors++; $display("FAIL loss_hold: fault=%b cause=%b want 1/01", fault, fault_cause); end
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        checks++; if (fault !== 1'b0 || sys_rst !== 1'b1) begin errors++; $display("FAIL loss_clr: fault=%b sys_rst=%b want 0/1", fault, sys_rst); end
        checks++; if (fault_cause !== 2'b00) begin errors++; $display("FAIL loss_clr_cause: got %b want 00", fault_cause); end
        repeat (10) @(negedge clk);
        checks++; if (clk_ok !== 1'b0) begin errors++; $display("FAIL loss_stay_wait: clk_ok=%b want 0", clk_ok); end
    endtask

    task automatic test_range_sweep();
        int n;
        int vals[6];
        use_async = 1'b0;
        vals[0] = 221; vals[1] = 222; vals[2] = 230; vals[3] = 231;
        vals[4] = int'($urandom_range(222, 230));
        vals[5] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(150, 221))
                                             : int'($urandom_range(231, 300));
        for (int i = 0; i < 6; i++) begin
            pat_n = vals[i];
            lock_after_valid();
            for (int k = 1; k <= 3; k++) begin
                wait_valid(1100, n);
                if (k == 1) begin
                    checks++; if (n != 1003) begin errors++; $display("FAIL sweep%0d_latency: got %0d want 1003", vals[i], n); end
                end
                checks++; if (meas_count !== 16'(vals[i])) begin errors++; $display("FAIL sweep%0d_count: got %0d want %0d", vals[i], meas_count, vals[i]); end
            end
            checks++; if (clk_ok !== in_window(vals[i])) begin errors++; $display("FAIL sweep%0d_release: clk_ok=%b want %b", vals[i], clk_ok, in_window(vals[i])); end
            unlock_and_clear();
        end
    endtask

    task automatic test_freq_fault();
        int n;
        pat_n = ExpectCount;
        lock_after_valid();
        for (int k = 1; k <= 3; k++) wait_valid(1100, n);
        checks++; if (clk_ok !== 1'b1) begin errors++; $display("FAIL freq_pre_run: clk_ok=%b want 1", clk_ok); end
        wait_valid(1100, n);
        pat_n = 250;
        wait_valid(1100, n);
        checks++; if (fault !== 1'b1 || fault_cause !== 2'b10) begin errors++; $display("FAIL freq_fault: fault=%b cause=%b want 1/10", fault, fault_cause); end
        checks++; if (meas_count < 245 || meas_count > 252) begin errors++; $display("FAIL freq_first_count: got %0d want 245..252", meas_count); end
        wait_valid(1100, n);
        checks++; if (meas_count !== 16'd250) begin errors++; $display("FAIL freq_count: got %0d want 250", meas_count); end
        checks++; if (fault_cause !== 2'b10) begin errors++; $display("FAIL freq_hold: cause=%b want 10", fault_cause); end
        pat_n = ExpectCount;
        wait_valid(1100, n);
    endtask

    // Clear while lock is still held: straight back through qualification to RUN.
    task automatic test_back_to_back();
        int n;
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            wait_valid(1100, n);
            checks++; if (n != ((k == 1) ? 1001 : 1000)) begin errors++; $display("FAIL b2b_win%0d_latency: got %0d want %0d", k, n, (k == 1) ? 1001 : 1000); end
            checks++; if (meas_count !== 16'd226) begin errors++; $display("FAIL b2b_win%0d_count: got %0d want 226", k, meas_count); end
            checks++; if (clk_ok !== (k == 3)) begin errors++; $display("FAIL b2b_win%0d_clk_ok: got %b want %b", k, clk_ok, k == 3); end
        end
    endtask

    task automatic test_stop_window();
        int n;
        unlock_and_clear();
        pat_n = ExpectCount;
        lock_after_valid();
        for (int k = 1; k <= 7; k++) begin
            wait_valid(1100, n);
            if (k == 3) begin
                checks++; if (meas_count >= 16'd222) begin errors++; $display("FAIL stop_win3_count: got %0d want <222", meas_count); end
            end else if (k == 4) begin
                checks++; if (meas_count !== 16'd0) begin errors++; $display("FAIL stop_win4_count: got %0d want 0", meas_count); end
            end else if (k == 5) begin
                checks++; if (meas_count < 225 || meas_count > 226) begin errors++; $display("FAIL stop_win5_count: got %0d want 225..226", meas_count); end
            end else begin
                checks++; if (meas_count !== 16'd226) begin errors++; $display("FAIL stop_win%0d_count: got %0d want 226", k, meas_count); end
            end
            checks++; if (clk_ok !== (k == 7)) begin errors++; $display("FAIL stop_win%0d_clk_ok: got %b want %b", k, clk_ok, k == 7); end
            if (k == 2) pat_n = 0;
            if (k == 4) pat_n = ExpectCount;
        end
    endtask

    task automatic test_double_cause();
        int n;
        wait_valid(1100, n);
        pat_n = 0;
        repeat (997) @(posedge clk);
        @(negedge clk);
        pll_locked = 1'b0;
        wait_valid(10, n);
        checks++; if (n != 3) begin errors++; $display("FAIL double_latency: got %0d want 3", n); end
        checks++; if (fault !== 1'b1 || fault_cause !== 2'b11) begin errors++; $display("FAIL double_cause: fault=%b cause=%b want 1/11", fault, fault_cause); end
        pat_n = ExpectCount;
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
    endtask

    task automatic test_async_reset();
        int n;
        lock_after_valid();
        for (int k = 1; k <= 3; k++) wait_valid(1100, n);
        checks++; if (clk_ok !== 1'b1) begin errors++; $display("FAIL arst_pre_run: clk_ok=%b want 1", clk_ok); end
        repeat (300) @(negedge clk);
        #3000;
        rst = 1'b1;
        #1000;
        checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL arst_sys_rst: got %b want 1", sys_rst); end
        checks++; if (clk_ok !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL arst_flags: clk_ok=%b fault=%b want 0/0", clk_ok, fault); end
        checks++; if (fault_cause !== 2'b00 || meas_valid !== 1'b0) begin errors++; $display("FAIL arst_cause_valid: cause=%b valid=%b want 00/0", fault_cause, meas_valid); end
        checks++; if (meas_count !== 16'd0) begin errors++; $display("FAIL arst_meas: got %0d want 0", meas_count); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            wait_valid(1100, n);
            checks++; if (n != ((k == 1) ? 1003 : 1000)) begin errors++; $display("FAIL arst_win%0d_latency: got %0d want %0d", k, n, (k == 1) ? 1003 : 1000); end
            checks++; if (meas_count !== 16'd226) begin errors++; $display("FAIL arst_win%0d_count: got %0d want 226", k, meas_count); end
            checks++; if (clk_ok !== (k == 3)) begin errors++; $display("FAIL arst_win%0d_clk_ok: got %b want %b", k, clk_ok, k == 3); end
        end
        checks++; if (sys_rst !== 1'b0) begin errors++; $display("FAIL arst_release: sys_rst=%b want 0", sys_rst); end
    endtask

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exceeded after %0d checks", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_lock_release();
        test_lock_loss();
        test_range_sweep();
        test_freq_fault();
        test_back_to_back();
        test_stop_window();
        test_double_cause();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
